// File: rtl/led_sched.sv
// led_sched: 8-LED pattern scheduler (PASS/CHASE/BLINK/COUNT) stepped by a push button.
// Define LED_SCHED_DEBOUNCE_EN to add a DB_CYCLES stability filter on dip and btn.

module led_sched_cond #(
   parameter int unsigned W = 8
`ifdef LED_SCHED_DEBOUNCE_EN
   ,
   parameter int unsigned DB_CYCLES = 500000
`endif
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] raw,
   output logic [W-1:0] cond
);

   logic [W-1:0] s1;
   logic [W-1:0] s2;

   // Two-flop synchronizer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef LED_SCHED_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic [W-1:0]  last;
   logic [W-1:0]  db;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   // Run length of the current synchronized value; any change restarts at one
   assign cnt_nxt = (s2 != last) ? CW'(1) : cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last <= '0;
         db   <= '0;
         cnt  <= '0;
      end else begin
         last <= s2;
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt_nxt >= CW'(DB_CYCLES)) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt_nxt;
         end
      end
   end

   assign cond = db;
`else
   assign cond = s2;
`endif

endmodule

module led_sched #(
   parameter int unsigned TICK_DIV  = 25000000,
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] dip,
   input  logic       btn,
   output logic [7:0] led,
   output logic [1:0] mode
);

   localparam int unsigned PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      CHASE = 2'd1,
      BLINK = 2'd2,
      COUNT = 2'd3
   } mode_e;

   if (TICK_DIV < 2 || TICK_DIV > 32'd16777216) begin : g_bad_tick_div
      $error("TICK_DIV out of range 2..2^24");
   end
   if (DB_CYCLES < 1 || DB_CYCLES > 32'd1048576) begin : g_bad_db_cycles
      $error("DB_CYCLES out of range 1..2^20");
   end

   logic [7:0] dip_c;
   logic       btn_c;

`ifdef LED_SCHED_DEBOUNCE_EN
   led_sched_cond #(.W(8), .DB_CYCLES(DB_CYCLES)) u_dip (
      .clk(clk), .rst_n(rst_n), .raw(dip), .cond(dip_c));
   led_sched_cond #(.W(1), .DB_CYCLES(DB_CYCLES)) u_btn (
      .clk(clk), .rst_n(rst_n), .raw(btn), .cond(btn_c));
`else
   led_sched_cond #(.W(8)) u_dip (
      .clk(clk), .rst_n(rst_n), .raw(dip), .cond(dip_c));
   led_sched_cond #(.W(1)) u_btn (
      .clk(clk), .rst_n(rst_n), .raw(btn), .cond(btn_c));
`endif

   mode_e         st;
   logic          btn_prev;
   logic [PW-1:0] presc;
   logic [7:0]    chase;
   logic [7:0]    cnt;
   logic          phase_on;
   logic          step_c;
   logic          tick_c;

   // btn_prev resets high so a button held through reset must be seen low first
   assign step_c = btn_c & ~btn_prev;
   assign tick_c = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= PASS;
         btn_prev <= 1'b1;
         presc    <= '0;
         chase    <= 8'h01;
         cnt      <= 8'h00;
         phase_on <= 1'b1;
         led      <= 8'h00;
      end else begin
         btn_prev <= btn_c;

         case (st)
            PASS:    led <= dip_c;
            CHASE:   led <= chase;
            BLINK:   led <= phase_on ? dip_c : 8'h00;
            COUNT:   led <= cnt;
            default: led <= 8'h00;
         endcase

         // A mode step restarts every pattern and swallows a coincident tick
         if (step_c) begin
            st       <= mode_e'(st + 2'd1);
            presc    <= '0;
            chase    <= 8'h01;
            cnt      <= 8'h00;
            phase_on <= 1'b1;
         end else begin
            presc <= tick_c ? '0 : presc + PW'(1);
            if (tick_c) begin
               case (st)
                  CHASE:   chase    <= dip_c[7] ? {chase[0], chase[7:1]}
                                                : {chase[6:0], chase[7]};
                  BLINK:   phase_on <= ~phase_on;
                  COUNT:   cnt      <= cnt + 8'd1;
                  default: ;
               endcase
            end
         end
      end
   end

   assign mode = st;

endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: randomized scoreboard bench for led_sched against a behavioural model.
// Honours LED_SCHED_DEBOUNCE_EN to select the conditioning model.

module tb_led_sched;

   localparam int TD = 4;
   localparam int DB = 3;

   typedef struct packed {
      logic [7:0] led;
      logic [1:0] mode;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] dip = 8'h00;
   logic       btn = 1'b0;
   logic [7:0] led;
   logic [1:0] mode;

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];

   // Model state, shared read-only with the stimulus process
   int         m_mode;
   int         m_cyc;
   int         m_ticks;
   int         m_pos;
   logic [7:0] h1d, h2d, dbd;
   logic       h1b, h2b, dbb, pb;
   logic [7:0] wind[$];
   logic       winb[$];

   always #5 clk = ~clk;

   led_sched #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .dip  (dip),
      .btn  (btn),
      .led  (led),
      .mode (mode)
   );

   task automatic model_reset();
      m_mode = 0; m_cyc = 0; m_ticks = 0; m_pos = 0;
      h1d = 8'h00; h2d = 8'h00; dbd = 8'h00;
      h1b = 1'b0;  h2b = 1'b0;  dbb = 1'b0;
      pb  = 1'b1;
      wind.delete();
      winb.delete();
   endtask

   // Reference model: one expected output pair per clock edge
   initial begin : model
      logic [7:0] s2d, cd, pl;
      logic       s2b, cb, step, same;
      exp_t       e;
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            model_reset();
            e.led  = 8'h00;
            e.mode = 2'd0;
         end else begin
            // raw input reaches the conditioned logic two edges after it is sampled
            s2d = h2d; s2b = h2b;
            h2d = h1d; h2b = h1b;
            h1d = dip; h1b = btn;
`ifdef LED_SCHED_DEBOUNCE_EN
            cd = dbd; cb = dbb;
            wind.push_back(s2d);
            if (wind.size() > DB) void'(wind.pop_front());
            winb.push_back(s2b);
            if (winb.size() > DB) void'(winb.pop_front());
            same = 1'b1;
            foreach (wind[i]) if (wind[i] != s2d) same = 1'b0;
            if (wind.size() == DB && same && s2d != dbd) dbd = s2d;
            same = 1'b1;
            foreach (winb[i]) if (winb[i] != s2b) same = 1'b0;
            if (winb.size() == DB && same && s2b != dbb) dbb = s2b;
`else
            cd = s2d; cb = s2b;
`endif
            step = cb && !pb;
            pb   = cb;
            case (m_mode)
               0:       pl = cd;
               1:       pl = 8'(1 << m_pos);
               2:       pl = (m_ticks % 2 == 0) ? cd : 8'h00;
               default: pl = 8'(m_ticks % 256);
            endcase
            if (step) begin
               m_mode  = (m_mode + 1) % 4;
               m_cyc   = 0;
               m_ticks = 0;
               m_pos   = 0;
            end else begin
               if (m_cyc == TD - 1) begin
                  m_ticks++;
                  if (m_mode == 1) m_pos = cd[7] ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
               end
               m_cyc = (m_cyc + 1) % TD;
            end
            e.led  = pl;
            e.mode = 2'(m_mode);
         end
         expq.push_back(e);
      end
   end

   // Monitor: compare DUT outputs against the oldest expectation each cycle
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (led !== e.led || mode !== e.mode) begin
               errors++;
               $display("FAIL led/mode at %0t: got led=%02h mode=%0d, expected led=%02h mode=%0d",
                        $time, led, mode, e.led, e.mode);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hold);
      btn = 1'b1;
      cyc(hold);
      btn = 1'b0;
      cyc(DB + 8);
   endtask

   task automatic goto_mode(input int target);
      for (int i = 0; i < 8 && m_mode != target; i++) press(DB + 6);
   endtask

   initial begin : stim
      // Reset held two edges with A5 on the switches
      rst_n = 1'b0;
      dip   = 8'hA5;
      btn   = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(DB + 10);

      // PASS with random switch patterns
      for (int i = 0; i < 20; i++) begin
         dip = 8'($urandom);
         cyc($urandom_range(1, DB + 6));
      end

      // CHASE left past 8'h80, then right past 8'h01
      goto_mode(1);
      dip = 8'($urandom) & 8'h7F;
      cyc(12 * TD);
      dip = 8'($urandom) | 8'h80;
      cyc(12 * TD);

      // BLINK with 3C, then random values
      goto_mode(2);
      dip = 8'h3C;
      cyc(8 * TD);
      for (int i = 0; i < 6; i++) begin
         dip = 8'($urandom);
         cyc($urandom_range(TD, 4 * TD));
      end

      // COUNT through a full wrap
      goto_mode(3);
      cyc(256 * TD + 10);

      // Random mix of glitches, presses, switch changes and mid-run resets
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0:       press($urandom_range(1, 12));
            1:       begin btn = 1'b1; cyc($urandom_range(1, 2)); btn = 1'b0; cyc($urandom_range(1, 4)); end
            2:       dip = 8'($urandom);
            3:       begin rst_n = 1'b0; cyc($urandom_range(1, 2)); rst_n = 1'b1; end
            default: cyc($urandom_range(1, 3 * TD));
         endcase
      end

      // Reset out of COUNT at a nonzero count
      rst_n = 1'b1;
      btn   = 1'b0;
      cyc(DB + 8);
      goto_mode(3);
      cyc(8'h17 * TD + 2);
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(DB + 10);

      cyc(2);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, giving the pattern-step period in clk cycles (range 2 to 2^24).
REQ-002 The block SHALL have parameter DB_CYCLES, default 500000, giving the debounce stability window in clk cycles (range 1 to 2^20).
REQ-003 Port clk: input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n: input, 1 bit; reset is synchronous and active-low.
REQ-005 Port dip: input, 8 bits, raw asynchronous switch bank.
REQ-006 Port btn: input, 1 bit, raw asynchronous mode-step push button, active-high.
REQ-007 Port led: output, 8 bits, registered LED drive.
REQ-008 Port mode: output, 2 bits, registered current mode (0 PASS, 1 CHASE, 2 BLINK, 3 COUNT).

Function
REQ-009 dip and btn SHALL each pass through a two-flop synchronizer before any other use.
REQ-010 The prescaler SHALL count 0..TICK_DIV-1, assert an internal tick for one cycle when the count equals TICK_DIV-1, and wrap to 0.
REQ-011 The mode FSM SHALL advance PASS->CHASE->BLINK->COUNT->PASS on each rising edge of the conditioned btn; a held button SHALL advance exactly once.
REQ-012 On a mode change, the block SHALL clear the prescaler, load the chase register with 8'h01, clear the counter, and set the blink phase to on, all in the same cycle.
REQ-013 If a mode change and a tick occur in the same cycle, the mode change SHALL win and the tick SHALL be discarded.
REQ-014 PASS: led SHALL equal the conditioned dip value, registered one cycle.
REQ-015 CHASE: on each tick, the chase register SHALL rotate left when conditioned dip[7]=0 and right when dip[7]=1; 8'h80 rotates left to 8'h01, and 8'h01 rotates right to 8'h80; led equals the chase register.
REQ-016 BLINK: on each tick, the phase SHALL toggle; led SHALL equal the conditioned dip when the phase is on, else 8'h00.
REQ-017 COUNT: on each tick, the 8-bit counter SHALL increment modulo 256 (8'hFF->8'h00); led equals the counter.
REQ-018 The mode output SHALL update in the same cycle as the FSM state, and led SHALL show the new mode's initial pattern on the next cycle.
REQ-019 Only the active mode's pattern state SHALL advance on tick; the other modes' pattern registers SHALL hold.

Reset
REQ-020 While rst_n=0 at a clk edge, the block SHALL force led=8'h00, mode=PASS, prescaler=0, chase=8'h01, counter=0, blink phase=on, and clear the synchronizers and debounce state.
REQ-021 Reset asserted mid-operation SHALL take effect at the next clk edge regardless of any pending tick or btn edge.
REQ-022 The first btn rising edge after reset SHALL be detected only once the conditioned btn has first been observed low.

Configuration
REQ-023 Macro LED_SCHED_DEBOUNCE_EN defined: each synchronized input SHALL update its conditioned value only after it differs from that value and stays constant for DB_CYCLES consecutive cycles; any change within the window SHALL restart the count.
REQ-024 With LED_SCHED_DEBOUNCE_EN defined, a clean dip change in PASS mode SHALL appear on led DB_CYCLES+3 cycles after the change.
REQ-025 Macro LED_SCHED_DEBOUNCE_EN undefined: the conditioned value SHALL equal the synchronizer output, DB_CYCLES SHALL be ignored, and a dip change in PASS mode SHALL appear on led 3 cycles after the change.

Verification
REQ-026 Reset held 2 cycles with dip=8'hA5 -> led=8'h00 and mode=0 during reset; led=8'hA5 after the REQ-024/025 latency.
REQ-027 TICK_DIV=4; one btn press -> mode=1, led=8'h01; dip[7]=0 -> led 8'h02, 8'h04 every 4 cycles, 8'h80 wraps to 8'h01; dip[7]=1 -> 8'h01 then 8'h80.
REQ-028 TICK_DIV=4; press to COUNT; run 256 ticks -> led walks 8'h00..8'hFF and returns to 8'h00.
REQ-029 BLINK with dip=8'h3C -> led alternates 8'h3C, 8'h00 every TICK_DIV cycles, starting on 8'h3C.
REQ-030 LED_SCHED_DEBOUNCE_EN, DB_CYCLES=3; btn glitch high for 2 cycles -> mode unchanged; btn high 10 cycles -> exactly one advance; btn edge coincident with tick -> mode advances, no pattern step.
REQ-031 Assert rst_n=0 in COUNT with led=8'h17 -> next cycle led=8'h00, mode=0.
